tone_sequencer: RTL



---
 rtl/music_pkg.sv | 31 +++
 rtl/square_wave_gen.sv | 47 ++++
 rtl/tone_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/music_pkg.sv
// Shared types and default timing for the tone sequencer.
package music_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam int unsigned DEF_NOTE_CYCLES   = 12500000;
    localparam int unsigned DEF_GAP_CYCLES    = 1250000;
    localparam int unsigned DEF_SETTLE_CYCLES = 2;
    localparam logic [31:0] DEF_AMPLITUDE     = 32'd10000000;
    localparam logic [4:0]  MAX_SLOTS         = 5'd16;

    // Bits needed to hold the longest phase length, capped at 32.
    function automatic int unsigned dur_width(input int unsigned note_c,
                                              input int unsigned gap_c,
                                              input int unsigned settle_c);
        longint unsigned m;
        int unsigned     w;
        m = longint'(note_c);
        if (longint'(gap_c) > m) m = longint'(gap_c);
        if (longint'(settle_c) + 64'd1 > m) m = longint'(settle_c) + 64'd1;
        w = 1;
        while ((w < 32) && ((64'd1 << w) <= m)) w++;
        return w;
    endfunction

endpackage

// File: rtl/square_wave_gen.sv
// Square-wave generator: captures a half-period on load, toggles phase while enabled.
module square_wave_gen
    import music_pkg::*;
#(
    parameter logic [31:0] AMPLITUDE = DEF_AMPLITUDE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               en,
    input  logic [31:0]        freq_in,
    output logic signed [31:0] audio_out
);

    logic [31:0] freq_reg;
    logic [31:0] hp_cnt;
    logic        phase;

    // Half-period counter and phase; load restarts every note on the low phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            freq_reg <= '0;
            hp_cnt   <= '0;
            phase    <= 1'b0;
        end else if (load) begin
            freq_reg <= freq_in;
            hp_cnt   <= '0;
            phase    <= 1'b0;
        end else if (en && (freq_reg != '0)) begin
            if (hp_cnt == freq_reg - 32'd1) begin
                hp_cnt <= '0;
                phase  <= ~phase;
            end else begin
                hp_cnt <= hp_cnt + 32'd1;
            end
        end
    end

    // Sample is driven only while playing a non-rest note; all inputs are flops.
    always_comb begin
        audio_out = '0;
        if (en && (freq_reg != '0)) begin
            audio_out = phase ? $signed(AMPLITUDE) : -$signed(AMPLITUDE);
        end
    end

endmodule

// File: rtl/tone_sequencer.sv
// Tone sequencer: steps through note slots, playing each for a fixed time
// followed by a silent gap.
//
//  state | meaning
//  IDLE  | waiting for start; outputs quiet
//  LOAD  | note_counter presented, waiting for freq_in to settle, then capture
//  PLAY  | square wave running for NOTE_CYCLES
//  GAP   | silence for GAP_CYCLES, then next slot / wrap / finish
module tone_sequencer
    import music_pkg::*;
#(
    parameter int unsigned NOTE_CYCLES   = DEF_NOTE_CYCLES,
    parameter int unsigned GAP_CYCLES    = DEF_GAP_CYCLES,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter logic [31:0] AMPLITUDE     = DEF_AMPLITUDE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               loop,
    input  logic [4:0]         num_notes,
    input  logic [31:0]        freq_in,
    output logic [3:0]         note_counter,
    output logic               ld_play,
    output logic signed [31:0] audio_out,
    output logic               busy,
    output logic               done
);

    localparam int unsigned DUR_W = dur_width(NOTE_CYCLES, GAP_CYCLES, SETTLE_CYCLES);

    // Down-counter reload values: phase ends when the counter reaches zero.
    localparam logic [DUR_W-1:0] SETTLE_LAST = DUR_W'(SETTLE_CYCLES);
    localparam logic [DUR_W-1:0] NOTE_LAST   = DUR_W'((NOTE_CYCLES > 0) ? NOTE_CYCLES - 1 : 0);
    localparam logic [DUR_W-1:0] GAP_LAST    = DUR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [DUR_W-1:0] DUR_ONE     = DUR_W'(1);

    state_t           state;
    logic [DUR_W-1:0] dur_cnt;
    logic [4:0]       eff_notes;
    logic             last_slot;
    logic             dur_tc;
    logic             note_end;
    logic             gen_load;
    logic             gen_en;

    // Terminal-count and slot decisions shared by the FSM and the generator.
    always_comb begin
        eff_notes = (num_notes > MAX_SLOTS) ? MAX_SLOTS : num_notes;
        last_slot = ({1'b0, note_counter} + 5'd1) >= eff_notes;
        dur_tc    = (dur_cnt == '0);
        note_end  = dur_tc && ((state == ST_GAP) ||
                               ((state == ST_PLAY) && (GAP_CYCLES == 0)));
        gen_load  = (state == ST_LOAD) && dur_tc;
        gen_en    = (state == ST_PLAY);
    end

    // Sequencer FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            dur_cnt      <= '0;
            note_counter <= '0;
            ld_play      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state        <= ST_IDLE;
                dur_cnt      <= '0;
                note_counter <= '0;
                ld_play      <= 1'b0;
                busy         <= 1'b0;
            end else if (note_end) begin
                if (!last_slot) begin
                    state        <= ST_LOAD;
                    dur_cnt      <= SETTLE_LAST;
                    note_counter <= note_counter + 4'd1;
                end else if (loop) begin
                    state        <= ST_LOAD;
                    dur_cnt      <= SETTLE_LAST;
                    note_counter <= '0;
                end else begin
                    // Finished: return the slot index to its idle value.
                    state        <= ST_IDLE;
                    dur_cnt      <= '0;
                    note_counter <= '0;
                    ld_play      <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b1;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            if (num_notes != '0) begin
                                state        <= ST_LOAD;
                                dur_cnt      <= SETTLE_LAST;
                                note_counter <= '0;
                                ld_play      <= 1'b1;
                                busy         <= 1'b1;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    ST_LOAD: begin
                        if (dur_tc) begin
                            state   <= ST_PLAY;
                            dur_cnt <= NOTE_LAST;
                        end else begin
                            dur_cnt <= dur_cnt - DUR_ONE;
                        end
                    end
                    ST_PLAY: begin
                        if (dur_tc) begin
                            state   <= ST_GAP;
                            dur_cnt <= GAP_LAST;
                        end else begin
                            dur_cnt <= dur_cnt - DUR_ONE;
                        end
                    end
                    ST_GAP: begin
                        dur_cnt <= dur_cnt - DUR_ONE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    square_wave_gen #(
        .AMPLITUDE (AMPLITUDE)
    ) u_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (gen_load),
        .en        (gen_en),
        .freq_in   (freq_in),
        .audio_out (audio_out)
    );

endmodule
